onehot_strobe_decoder: RTL and testbench
========================================

Name: onehot_strobe_decoder

Overview:
- Inverse of the team's 8-to-3 priority encoder. It accepts a 3-bit channel code over a valid/ready handshake and drives a one-hot 8-bit strobe for a programmable number of cycles.
- Bit mapping mirrors the encoder: code 3'b000 selects o[7], code 3'b111 selects o[0].
- Used to fire per-channel enables from an encoded index.
- A mandatory one-cycle gap separates consecutive strobes.

Parameters:
- PULSE_LEN, 4: strobe length in clock cycles. Legal range is 1 to 255.
- CNT_W, $clog2(PULSE_LEN+1): cycle-counter width. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- code  input  3  channel index; 000 maps to o[7], 111 maps to o[0]
- valid  input  1  code is valid this cycle
- ready  output  1  block can accept a code (high only in IDLE)
- o  output  8  registered one-hot strobe; all-zero when not ACTIVE
- busy  output  1  high in ACTIVE or GAP
- done  output  1  one-cycle pulse in the GAP cycle that ends every strobe
- abort  input  1  present only with DEC_ABORT_EN (see Optional Feature)

Behaviour:
- Reset:
  - rst_n low forces, asynchronously: state=IDLE, o=8'h00, done=0, counter=0, stored code=0.
  - ready=1 and busy=0 follow from IDLE.
  - Reset mid-strobe clears o immediately, without waiting for a clock edge.
- States: IDLE, ACTIVE, GAP.
  - ready = (state==IDLE), combinational from state.
  - busy = (state!=IDLE).
- IDLE:
  - Accept when valid && ready at a rising edge: register code, load counter with PULSE_LEN-1, go to ACTIVE.
  - o is asserted from that same edge, i.e. latency 1 cycle from the accept edge.
- ACTIVE:
  - o = 8'b1 << (7 - stored_code).
  - Counter decrements each cycle.
  - When counter==0, the next state is GAP. The strobe is therefore exactly PULSE_LEN cycles.
- GAP:
  - Exactly one cycle: o=8'h00, done=1, ready=0.
  - Next state is IDLE unconditionally.
- Handshake rules:
  - valid while busy is ignored; there is no queueing and no error flag.
  - The source must hold valid until it sees ready.
  - code is sampled only at the accept edge. Later changes to code do not affect o.
- Throughput: one strobe every PULSE_LEN+2 cycles maximum. A back-to-back valid is accepted on the first IDLE cycle after GAP.
- PULSE_LEN=1: ACTIVE lasts one cycle, the counter loads 0, then GAP.
- o is never multi-hot and never X. An X or Z on code at the accept edge is a source error; no detection is required.
- done is registered and is never high outside GAP.

Optional Feature:
- Macro: DEC_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort sampled high in ACTIVE: next state is GAP. o clears at that edge, done pulses for one cycle as normal, then IDLE.
  - abort in IDLE or GAP is ignored.
  - abort asserted in the same cycle as an accept is ignored; the strobe starts normally.
- Not defined:
  - Port absent; no abort logic.
  - The strobe always runs the full PULSE_LEN cycles.

Test Plan (PULSE_LEN=4 unless stated):
- Reset check: hold rst_n=0 with valid=1, code=3'b010 → o=8'h00, ready=1, busy=0, done=0. After release, accept at the first edge; o=8'b00100000 for 4 cycles.
- Sweep: codes 000..111 in sequence, each held until accepted → o goes 8'h80, 8'h40 … 8'h01, each 4 cycles. Each strobe is followed by 1 GAP cycle with done=1. Accepts are 6 cycles apart.
- Busy handling: during ACTIVE, change code to 3'b111 with valid=1 → o is unchanged and no second accept occurs until IDLE. The next strobe is then 8'h01.
- Async reset mid-strobe: drop rst_n in cycle 2 of ACTIVE (between edges) → o=8'h00 immediately and state is IDLE. No done pulse appears.
- PULSE_LEN=1 build: code=3'b000 → o=8'h80 for exactly 1 cycle, done for 1 cycle, ready high on the third cycle after accept.
- With DEC_ABORT_EN: code=3'b011 accepted, abort=1 in cycle 2 of ACTIVE → o=8'h10 for 2 cycles then 8'h00, done=1 for one cycle, then IDLE. abort=1 in IDLE has no effect.

Source files
------------

// File: rtl/onehot_strobe_decoder.sv
// Decodes a 3-bit channel code into a one-hot 8-bit strobe held for PULSE_LEN cycles,
// followed by a one-cycle gap with done. Optional DEC_ABORT_EN adds an abort input.
module onehot_strobe_decoder #(
    parameter int unsigned PULSE_LEN = 4,
    localparam int unsigned CNT_W = $clog2(PULSE_LEN + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] code,
    input  logic       valid,
`ifdef DEC_ABORT_EN
    input  logic       abort,
`endif
    output logic       ready,
    output logic [7:0] o,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       code_q, code_d;
    logic [7:0]       o_d;
    logic             done_d;
    logic             end_strobe;

    // State register plus registered strobe and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= 3'd0;
            o       <= 8'h00;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            o       <= o_d;
            done    <= done_d;
        end
    end

    // Strobe ends on the last counted cycle, or early when aborted.
`ifdef DEC_ABORT_EN
    assign end_strobe = (cnt_q == '0) || abort;
`else
    assign end_strobe = (cnt_q == '0);
`endif

    // Next-state and next-output logic; o/done are computed for the cycle after the edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        o_d     = 8'h00;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = ACTIVE;
                    code_d  = code;
                    cnt_d   = CNT_W'(PULSE_LEN - 1);
                    o_d     = 8'h80 >> code;
                end
            end
            ACTIVE: begin
                if (end_strobe) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    o_d   = 8'h80 >> code_q;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Self-checking bench for onehot_strobe_decoder; honours DEC_ABORT_EN when defined.
module tb_onehot_strobe_decoder;

    localparam int unsigned PL = 4;
`ifdef DEC_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       valid = 1'b0;
    logic       abort_in = 1'b0;
    logic [2:0] code = 3'd0;
    logic       ready, busy, done;
    logic [7:0] o;

    int checks = 0;
    int failures = 0;

    // Reference model: elapsed cycles since the accept edge against the strobe length.
    bit         m_idle = 1'b1;
    int         since = 0;
    int         len = PL;
    logic [2:0] mcode = 3'd0;
    bit         acc_now = 1'b0;
    int         cyc = 0;
    int         last_acc = -100;

    onehot_strobe_decoder #(.PULSE_LEN(PL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .code  (code),
        .valid (valid),
`ifdef DEC_ABORT_EN
        .abort (abort_in),
`endif
        .ready (ready),
        .o     (o),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [7:0] exp_o;
        bit         act;
        act   = !m_idle && (since <= len);
        exp_o = act ? (8'h80 >> mcode) : 8'h00;
        chk("o", 32'(o), 32'(exp_o));
        chk("ready", 32'(ready), 32'(m_idle));
        chk("busy", 32'(busy), 32'(!m_idle));
        chk("done", 32'(done), 32'(!m_idle && (since == len + 1)));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then check #1 later.
    task automatic step();
        acc_now = 1'b0;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_idle = 1'b1;
        end else if (m_idle) begin
            if (valid) begin
                m_idle  = 1'b0;
                since   = 1;
                len     = PL;
                mcode   = code;
                acc_now = 1'b1;
            end
        end else begin
            if (ABORT_EN && abort_in && since <= len) len = since;
            since++;
            if (since > len + 1) m_idle = 1'b1;
        end
        #1;
        check_outputs();
    endtask

    // Hold valid with code c until accepted (bounded); optionally check accept spacing.
    task automatic send(input logic [2:0] c, input bit chk_gap);
        valid = 1'b1;
        code  = c;
        for (int i = 0; i < 3 * PL + 10; i++) begin
            step();
            if (acc_now) break;
        end
        chk("accept_seen", 32'(acc_now), 32'd1);
        if (chk_gap) chk("accept_spacing", 32'(cyc - last_acc), 32'(PL + 2));
        last_acc = cyc;
        valid = 1'b0;
        code  = 3'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            code = 3'($urandom);
            step();
        end
    endtask

    initial begin
        // Reset held with a pending request
        #1 rst_n = 1'b0;
        valid = 1'b1;
        code  = 3'b010;
        #1 check_outputs();
        step();
        step();
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("accept_after_reset", 32'(acc_now), 32'd1);
        chk("o_after_reset", 32'(o), 32'h20);
        valid = 1'b0;
        run(PL + 2);

        // Sweep all codes back to back
        send(3'd0, 1'b0);
        for (int c = 1; c < 8; c++) send(3'(c), 1'b1);
        run(PL + 2);

        // Busy handling: a new request while active is ignored until idle
        send(3'b010, 1'b0);
        step();
        send(3'b111, 1'b0);
        chk("busy_next_strobe", 32'(o), 32'h01);
        run(PL + 2);

        // Async reset in cycle 2 of ACTIVE, between edges
        send(3'b101, 1'b0);
        step();
        #2 rst_n = 1'b0;
        m_idle = 1'b1;
        #1 check_outputs();
        chk("o_async_clear", 32'(o), 32'h00);
        step();
        @(negedge clk) rst_n = 1'b1;
        run(3);

        if (ABORT_EN) begin
            // Abort in cycle 2 of ACTIVE
            send(3'b011, 1'b0);
            step();
            abort_in = 1'b1;
            step();
            abort_in = 1'b0;
            chk("abort_gap_done", 32'(done), 32'd1);
            chk("abort_o_clear", 32'(o), 32'h00);
            run(2);
            // Abort in IDLE and together with accept is ignored
            abort_in = 1'b1;
            run(2);
            send(3'b001, 1'b0);
            abort_in = 1'b0;
            run(PL + 2);
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            valid    = 1'($urandom_range(0, 1));
            code     = 3'($urandom);
            abort_in = ABORT_EN && ($urandom_range(0, 7) == 0);
            step();
        end
        valid    = 1'b0;
        abort_in = 1'b0;
        run(PL + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
